// File: rtl/dma_addr_pkg.sv
// Shared constants and helpers for the multi-channel DMA address generator.
package dma_addr_pkg;

    localparam int ADDR_W_MIN = 9;
    localparam int ADDR_W_MAX = 16;
    localparam int NUM_CH_MIN = 1;
    localparam int NUM_CH_MAX = 4;

    localparam logic [3:0] OFF_CLR_PTR = 4'hC;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_READ  = 2'd2
    } acc_kind_e;

    // Smallest select width that can address n channels (at least 1 bit).
    function automatic int ch_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/dma_ch_regs.sv
// One DMA channel: base/current address and word count, CPU byte loads and
// per-transfer stepping with terminal-count detection and optional auto-init.
module dma_ch_regs
    import dma_addr_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              wr_addr,
    input  logic              wr_cnt,
    input  logic              wr_hi,
    input  logic [7:0]        wr_data,
    input  logic              step_en,
    input  logic              dec,
    input  logic              autoinit,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] cur_cnt,
    output logic              tc_event
);

    localparam int HI_W = ADDR_W - 8;
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] base_addr_q, base_addr_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic [ADDR_W-1:0] base_cnt_q,  base_cnt_d;
    logic [ADDR_W-1:0] cur_cnt_q,   cur_cnt_d;
    logic [ADDR_W-1:0] step_addr;

    assign step_addr = dec ? (cur_addr_q - ONE) : (cur_addr_q + ONE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        base_addr_d = base_addr_q;
        cur_addr_d  = cur_addr_q;
        base_cnt_d  = base_cnt_q;
        cur_cnt_d   = cur_cnt_q;
        tc_event    = 1'b0;

        if (wr_addr) begin
            if (wr_hi) begin
                base_addr_d[ADDR_W-1:8] = wr_data[HI_W-1:0];
                cur_addr_d[ADDR_W-1:8]  = wr_data[HI_W-1:0];
            end else begin
                base_addr_d[7:0] = wr_data;
                cur_addr_d[7:0]  = wr_data;
            end
        end

        if (wr_cnt) begin
            if (wr_hi) begin
                base_cnt_d[ADDR_W-1:8] = wr_data[HI_W-1:0];
                cur_cnt_d[ADDR_W-1:8]  = wr_data[HI_W-1:0];
            end else begin
                base_cnt_d[7:0] = wr_data;
                cur_cnt_d[7:0]  = wr_data;
            end
        end

        // A step on an exhausted count is the terminal event; count wraps unless reloaded.
        if (step_en) begin
            if (cur_cnt_q == '0) begin
                tc_event = 1'b1;
            end
            if ((cur_cnt_q == '0) && autoinit) begin
                cur_addr_d = base_addr_q;
                cur_cnt_d  = base_cnt_q;
            end else begin
                cur_addr_d = step_addr;
                cur_cnt_d  = cur_cnt_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            base_addr_q <= '0;
            cur_addr_q  <= '0;
            base_cnt_q  <= '0;
            cur_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
            base_addr_q <= base_addr_d;
            cur_addr_q  <= cur_addr_d;
            base_cnt_q  <= base_cnt_d;
            cur_cnt_q   <= cur_cnt_d;
        end
    end

    assign cur_addr = cur_addr_q;
    assign cur_cnt  = cur_cnt_q;

endmodule

// File: rtl/dma_addr_gen.sv
// DMA address/count generator: CPU register access with byte pointer, per-channel
// stepping, terminal-count pulse and the tri-state system address bus.
module dma_addr_gen
    import dma_addr_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cs_n,
    input  logic              iow_n,
    input  logic              ior_n,
    input  logic              AEN,
    input  logic [3:0]        reg_sel,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    inout  wire  [ADDR_W-1:0] address_bus,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              step,
    input  logic [NUM_CH-1:0] mode_dec,
    input  logic [NUM_CH-1:0] mode_autoinit,
    output logic              tc,
    output logic [CH_W-1:0]   tc_ch
);

    logic            iow_hist_q, ior_hist_q;
    logic            ptr_q, ptr_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            tc_q, tc_d;
    logic [CH_W-1:0] tc_ch_q, tc_ch_d;

    acc_kind_e   acc_kind;
    logic [2:0]  reg_ch;
    logic        reg_is_cnt;
    logic        reg_valid;

    logic [ADDR_W-1:0] cur_addr_arr [NUM_CH];
    logic [ADDR_W-1:0] cur_cnt_arr  [NUM_CH];
    logic [NUM_CH-1:0] tc_event;
    logic [ADDR_W-1:0] rd_word;
    logic [7:0]        rd_byte;
    logic [ADDR_W-1:0] bus_addr;

    assign reg_ch     = reg_sel[3:1];
    assign reg_is_cnt = reg_sel[0];
    assign reg_valid  = int'(reg_ch) < NUM_CH;

    // An access is the first sampled-low cycle of a strobe; write wins if both fall together.
    always_comb begin
        acc_kind = ACC_NONE;
        if (!cs_n && !AEN) begin
            if (iow_hist_q && !iow_n) begin
                acc_kind = ACC_WRITE;
            end else if (ior_hist_q && !ior_n) begin
                acc_kind = ACC_READ;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic sel_this;
        assign sel_this = (acc_kind == ACC_WRITE) && (reg_ch == 3'(g));

        dma_ch_regs #(.ADDR_W(ADDR_W)) u_ch (
            .clk      (clk),
            .Reset    (Reset),
            .wr_addr  (sel_this && !reg_is_cnt),
            .wr_cnt   (sel_this && reg_is_cnt),
            .wr_hi    (ptr_q),
            .wr_data  (data_in),
            .step_en  (AEN && step && (ch_sel == CH_W'(g))),
            .dec      (mode_dec[g]),
            .autoinit (mode_autoinit[g]),
            .cur_addr (cur_addr_arr[g]),
            .cur_cnt  (cur_cnt_arr[g]),
            .tc_event (tc_event[g])
        );
    end

    always_comb begin
        rd_word  = '0;
        bus_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (reg_ch == 3'(i)) begin
                rd_word = reg_is_cnt ? cur_cnt_arr[i] : cur_addr_arr[i];
            end
            if (ch_sel == CH_W'(i)) begin
                bus_addr = cur_addr_arr[i];
            end
        end
        rd_byte = ptr_q ? 8'(rd_word[ADDR_W-1:8]) : rd_word[7:0];
    end

    always_comb begin
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        tc_d       = |tc_event;
        tc_ch_d    = (|tc_event) ? ch_sel : tc_ch_q;
        case (acc_kind)
            ACC_WRITE: begin
                if (reg_valid) begin
                    ptr_d = ~ptr_q;
                end else if (reg_sel == OFF_CLR_PTR) begin
                    ptr_d = 1'b0;
                end
            end
            ACC_READ: begin
                data_out_d = reg_valid ? rd_byte : 8'h00;
                if (reg_valid) begin
                    ptr_d = ~ptr_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            iow_hist_q <= 1'b1;
            ior_hist_q <= 1'b1;
            ptr_q      <= 1'b0;
            data_out_q <= 8'h00;
            tc_q       <= 1'b0;
            tc_ch_q    <= '0;
        end else begin
            iow_hist_q <= iow_n;
            ior_hist_q <= ior_n;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            tc_q       <= tc_d;
            tc_ch_q    <= tc_ch_d;
        end
    end

    assign data_out    = data_out_q;
    assign tc          = tc_q;
    assign tc_ch       = tc_ch_q;
    assign address_bus = AEN ? bus_addr : {ADDR_W{1'bz}};

endmodule

// File: tb/tb_dma_addr_gen.sv
// Scoreboard bench for dma_addr_gen: expectations are queued as stimulus is
// driven and popped against DUT outputs sampled on the falling clock edge.
module tb_dma_addr_gen;

    localparam int ADDR_W = 16;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam logic [3:0] CLR = 4'hC;

    logic              clk;
    logic              Reset;
    logic              cs_n, iow_n, ior_n, AEN;
    logic [3:0]        reg_sel;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    wire  [ADDR_W-1:0] address_bus;
    logic [CH_W-1:0]   ch_sel;
    logic              step;
    logic [NUM_CH-1:0] mode_dec, mode_autoinit;
    logic              tc;
    logic [CH_W-1:0]   tc_ch;

    logic [ADDR_W-1:0] tb_bus;
    logic              tb_bus_en;
    assign address_bus = tb_bus_en ? tb_bus : {ADDR_W{1'bz}};

    dma_addr_gen #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk           (clk),
        .Reset         (Reset),
        .cs_n          (cs_n),
        .iow_n         (iow_n),
        .ior_n         (ior_n),
        .AEN           (AEN),
        .reg_sel       (reg_sel),
        .data_in       (data_in),
        .data_out      (data_out),
        .address_bus   (address_bus),
        .ch_sel        (ch_sel),
        .step          (step),
        .mode_dec      (mode_dec),
        .mode_autoinit (mode_autoinit),
        .tc            (tc),
        .tc_ch         (tc_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic score(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic io_write(input logic [3:0] off, input logic [7:0] d);
        @(negedge clk);
        AEN = 1'b0; cs_n = 1'b0; reg_sel = off; data_in = d; iow_n = 1'b0;
        @(negedge clk);
        iow_n = 1'b1; cs_n = 1'b1;
    endtask

    task automatic io_read(input logic [3:0] off, input int hold, output logic [7:0] d);
        @(negedge clk);
        AEN = 1'b0; cs_n = 1'b0; reg_sel = off; ior_n = 1'b0;
        repeat (hold) @(negedge clk);
        d = data_out;
        ior_n = 1'b1; cs_n = 1'b1;
    endtask

    task automatic write_reg(input logic [3:0] off, input logic [15:0] v);
        io_write(CLR, 8'h00);
        io_write(off, v[7:0]);
        io_write(off, v[15:8]);
    endtask

    task automatic read_reg(input logic [3:0] off, input string tag, input logic [15:0] exp);
        logic [7:0] lo, hi;
        expect_val(tag, exp);
        io_write(CLR, 8'h00);
        io_read(off, 1, lo);
        io_read(off, 1, hi);
        score({hi, lo});
    endtask

    task automatic check_bus(input logic [CH_W-1:0] ch, input string tag, input logic [15:0] exp);
        @(negedge clk);
        AEN = 1'b1; ch_sel = ch;
        expect_val(tag, exp);
        #1 score(address_bus);
    endtask

    task automatic do_step(input logic [CH_W-1:0] ch, input string tag,
                           input logic [15:0] exp_addr, input logic exp_tc,
                           input logic [CH_W-1:0] exp_tc_ch);
        @(negedge clk);
        AEN = 1'b1; ch_sel = ch; step = 1'b1;
        expect_val({tag, "_addr"}, exp_addr);
        expect_val({tag, "_tc"}, exp_tc);
        if (exp_tc) expect_val({tag, "_tc_ch"}, exp_tc_ch);
        @(negedge clk);
        step = 1'b0;
        score(address_bus);
        score(tc);
        if (exp_tc) score(tc_ch);
        expect_val({tag, "_tc_drop"}, 1'b0);
        @(negedge clk);
        score(tc);
    endtask

    logic [7:0] rd;

    initial begin
        Reset = 1'b0; cs_n = 1'b1; iow_n = 1'b1; ior_n = 1'b1; AEN = 1'b0;
        reg_sel = '0; data_in = '0; ch_sel = '0; step = 1'b0;
        mode_dec = '0; mode_autoinit = '0; tb_bus = '0; tb_bus_en = 1'b0;

        repeat (3) @(negedge clk);
        expect_val("rst_data_out", 8'h00); score(data_out);
        expect_val("rst_tc", 1'b0);        score(tc);
        expect_val("rst_tc_ch", 2'd0);     score(tc_ch);
        Reset = 1'b1;

        // Byte-pointer write of ch0 address, bus drive and release
        io_write(4'h0, 8'h34);
        io_write(4'h0, 8'h12);
        check_bus(2'd0, "ch0_bus", 16'h1234);
        @(negedge clk);
        AEN = 1'b0; tb_bus = 16'hA5A5; tb_bus_en = 1'b1;
        expect_val("bus_release", 16'hA5A5);
        #1 score(address_bus);
        tb_bus_en = 1'b0;

        // Pointer clear mid-word
        io_write(4'h2, 8'h99);
        io_write(CLR, 8'h00);
        io_write(4'h2, 8'h78);
        io_write(4'h2, 8'h56);
        check_bus(2'd1, "ch1_bus", 16'h5678);

        // Incrementing wrap and terminal count without auto-init
        write_reg(4'h0, 16'hFFFF);
        write_reg(4'h1, 16'h0002);
        do_step(2'd0, "inc1", 16'h0000, 1'b0, 2'd0);
        do_step(2'd0, "inc2", 16'h0001, 1'b0, 2'd0);
        do_step(2'd0, "inc3", 16'h0002, 1'b1, 2'd0);
        read_reg(4'h1, "ch0_cnt_wrap", 16'hFFFF);

        // Decrement with auto-init reload
        write_reg(4'h4, 16'h0100);
        write_reg(4'h5, 16'h0001);
        mode_dec[2] = 1'b1; mode_autoinit[2] = 1'b1;
        do_step(2'd2, "dec1", 16'h00FF, 1'b0, 2'd0);
        do_step(2'd2, "ai2", 16'h0100, 1'b1, 2'd2);
        read_reg(4'h5, "ch2_cnt_reload", 16'h0001);

        // Back-to-back steps
        write_reg(4'h6, 16'h1000);
        write_reg(4'h7, 16'h0005);
        @(negedge clk);
        AEN = 1'b1; ch_sel = 2'd3; step = 1'b1;
        @(negedge clk);
        expect_val("b2b_1", 16'h1001); score(address_bus);
        @(negedge clk);
        step = 1'b0;
        expect_val("b2b_2", 16'h1002); score(address_bus);
        read_reg(4'h7, "ch3_cnt_b2b", 16'h0003);

        // Byte reads and a long strobe
        write_reg(4'h0, 16'hABCD);
        io_write(CLR, 8'h00);
        io_read(4'h0, 1, rd); expect_val("rd_lo", 8'hCD); score(rd);
        io_read(4'h0, 1, rd); expect_val("rd_hi", 8'hAB); score(rd);
        io_write(CLR, 8'h00);
        io_read(4'h0, 5, rd); expect_val("rd_long", 8'hCD); score(rd);
        io_read(4'h0, 1, rd); expect_val("rd_after_long", 8'hAB); score(rd);
        repeat (3) @(negedge clk);
        expect_val("rd_hold", 8'hAB); score(data_out);

        // Unmapped offsets: read 0, pointer untouched, write ignored
        io_write(CLR, 8'h00);
        io_read(4'h8, 1, rd); expect_val("rd_unmapped", 8'h00); score(rd);
        io_read(4'h0, 1, rd); expect_val("rd_ptr_kept", 8'hCD); score(rd);
        io_write(4'h8, 8'h77);
        io_read(4'h0, 1, rd); expect_val("wr_unmapped", 8'hAB); score(rd);

        // Slave write while AEN=1 is ignored
        @(negedge clk);
        AEN = 1'b1; cs_n = 1'b0; reg_sel = 4'h0; data_in = 8'h11; iow_n = 1'b0;
        @(negedge clk);
        iow_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        AEN = 1'b0;
        read_reg(4'h0, "aen_wr_ignored", 16'hABCD);

        // Step while AEN=0 is ignored
        @(negedge clk);
        AEN = 1'b0; ch_sel = 2'd0; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        expect_val("step_aen0_tc", 1'b0); score(tc);
        read_reg(4'h0, "step_aen0_addr", 16'hABCD);

        // Reset in the middle of programming and of a step
        io_write(CLR, 8'h00);
        io_write(4'h0, 8'h99);
        @(negedge clk);
        AEN = 1'b1; ch_sel = 2'd0; step = 1'b1;
        #2 Reset = 1'b0;
        #1;
        expect_val("mid_rst_bus", 16'h0000);  score(address_bus);
        expect_val("mid_rst_tc", 1'b0);       score(tc);
        expect_val("mid_rst_dout", 8'h00);    score(data_out);
        @(negedge clk);
        Reset = 1'b1; step = 1'b0;
        #1;
        expect_val("post_rst_bus", 16'h0000); score(address_bus);
        expect_val("post_rst_tc", 1'b0);      score(tc);
        io_write(4'h0, 8'h44);
        check_bus(2'd0, "post_rst_ptr", 16'h0044);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_addr_gen.md
Name: dma_addr_gen

Overview:
- Parametrised multi-channel address/count generator and address-bus buffer for the DMA controller; successor to the single-register I/O address buffer.
- Slave mode (AEN low): the CPU programs per-channel base/current address and word count over an 8-bit data path with a byte-pointer flip-flop.
- Master mode (AEN high): drives the active channel's current address onto the tri-state address bus and steps address/count per transfer, flagging terminal count with optional auto-init.

Parameters:
- ADDR_W, 16, address/count width; legal 9..16.
- NUM_CH, 4, channel count; legal 1..4.
- CH_W, 2, channel select width; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cs_n  in  1  chip select, active low.
- iow_n  in  1  CPU I/O write strobe, active low.
- ior_n  in  1  CPU I/O read strobe, active low.
- AEN  in  1  master-mode enable; 1 = block owns the address bus.
- reg_sel  in  4  register offset.
- data_in  in  8  CPU write data.
- data_out  out  8  CPU read data, registered.
- address_bus  inout  ADDR_W  system address bus.
- ch_sel  in  CH_W  active channel in master mode.
- step  in  1  one-cycle transfer-done pulse.
- mode_dec  in  NUM_CH  per channel: 1 = decrement address, 0 = increment.
- mode_autoinit  in  NUM_CH  per channel auto-init enable.
- tc  out  1  terminal-count pulse, one cycle.
- tc_ch  out  CH_W  channel that produced tc.

Behaviour:
- Reset low, asynchronous: all base/current registers 0, byte pointer 0, data_out 0, tc 0, tc_ch 0, strobe history registers 1.
- Strobes are sampled each clk. An access is a 1->0 transition of iow_n or ior_n while cs_n=0 and AEN=0. Each strobe low phase produces exactly one access.
- Register map: offset 2*ch = address of channel ch; offset 2*ch+1 = word count of channel ch; offset 0xC = clear byte pointer (write only). Other offsets and channels >= NUM_CH: writes ignored, reads return 0, pointer unchanged.
- Write access to address/count:
  - Pointer 0: low byte of base and current written.
  - Pointer 1: bits ADDR_W-1:8 written from data_in[ADDR_W-9:0]; upper data bits dropped.
  - Pointer toggles. Registers update on the cycle after the edge is detected.
- Read access to address/count: data_out loads the current register's low (ptr 0) or high (ptr 1, zero-extended) byte. Pointer toggles in the same cycle. Latency is 1 cycle after edge detection; data_out holds until the next read.
- Write to 0xC: pointer becomes 0.
- Address bus drive: address_bus = current_addr[ch_sel] while AEN=1, else high-Z. Combinational from AEN and ch_sel.
- Slave accesses with AEN=1 are ignored.
- step with AEN=1 acts on channel ch_sel:
  - Address becomes addr+1, or addr-1 when mode_dec is set; wraps mod 2**ADDR_W.
  - Count decrements.
  - If count was 0 before the step: tc=1 and tc_ch=ch_sel next cycle. If mode_autoinit is set, current address and count reload from base instead of updating; otherwise address updates and count wraps to all-ones.
- step with AEN=0 is ignored. Steps on consecutive cycles are legal; each updates.
- tc is high for exactly one cycle per terminal event.
- step with ch_sel >= NUM_CH: no effect.
- Reset asserted mid-programming clears the pointer, so the next write is a low byte.

Decomposition:
- Package dma_addr_pkg: register offset constants (OFF_CLR_PTR = 4'hC), ADDR_W/NUM_CH limits, and a clog2-style function for CH_W.
- Sub-module dma_ch_regs: one channel's base/current address and count registers, load and step logic, and tc_event output. Instantiated NUM_CH times via generate.
- The top level holds strobe edge detection, the byte pointer, the read mux and the bus tri-state.

Test Plan:
- Reset, then write 0x34 then 0x12 to offset 0 -> ch0 base and current address = 0x1234. With AEN=1 and ch_sel=0, address_bus = 0x1234; with AEN=0, address_bus is Z.
- Write low byte only, write 0xC, write 0x78, 0x56 to offset 2 -> ch1 address = 0x5678, proving the pointer clear.
- ch0 address 0xFFFF, count 0x0002, mode_dec=0: three steps -> address sequence 0x0000, 0x0001, 0x0002; tc pulses once, after the third step, with tc_ch=0; count = 0xFFFF.
- ch2 base 0x0100, count 0x0001, mode_dec=1, autoinit=1: two steps -> address 0x00FF, then reload to 0x0100/0x0001; tc pulse on the second step.
- Read offset 0 twice after ch0=0xABCD -> data_out 0xCD, then 0xAB. Hold ior_n low 5 cycles -> only one pointer toggle.
- Assert Reset mid-transfer with AEN=1 and step active -> all registers 0 immediately, tc=0, no step applied.
